// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and skid-buffer state encoding for the FIFO read controller
//
// Contents:
//   DATA_WIDTH_DEF  default read/stream data width
//   SKID_DEPTH_DEF  output buffer entries (the design only supports 2)
//   CNT_WIDTH       width of the optional accepted-word counter
//   skid_state_t    buffer occupancy state; the encoding equals the word count

package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int SKID_DEPTH_DEF = 2;
    localparam int CNT_WIDTH      = 16;

    // Encoding is chosen so that the state value is directly the buffered word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-entry output skid buffer with occupancy FSM
//
// Ports:
//   clk      clock
//   rstb     asynchronous active-low reset
//   wr_en    write a word into the buffer tail this cycle
//   wr_data  word to write
//   m_valid  output word valid (registered, high whenever count != 0)
//   m_ready  downstream accept
//   m_data   oldest buffered word (registered)
//   count    buffered word count 0..2

module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            count
);

    skid_state_t           state;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;

    assign pop   = m_valid && m_ready;
    assign count = state;

    // m_data is the head entry itself; tail holds the second word only in FULL.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            m_data  <= '0;
            tail    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (wr_en) begin
                        m_data  <= wr_data;
                        m_valid <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (wr_en && pop) begin
                        // Head leaves and the new word becomes head in the same edge.
                        m_data <= wr_data;
                    end else if (wr_en) begin
                        tail  <= wr_data;
                        state <= FULL;
                    end else if (pop) begin
                        m_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    // A write without a pop cannot occur here: the issue logic
                    // never lets count + inflight exceed two.
                    if (pop) begin
                        m_data <= tail;
                        if (wr_en) begin
                            tail <= wr_data;
                        end else begin
                            state <= ONE;
                        end
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read-side controller: pop issue, in-flight tracking, skid output
//
// Optional feature macro: FIFO_RD_CNT_EN (adds rd_count port and accepted-word counter)
//
// Ports:
//   clk           clock shared with the FIFO read side
//   rstb          asynchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO pop request (only asserted when the FIFO is non-empty)
//   fifo_rd_data  FIFO registered read data, valid the cycle after a pop
//   m_valid       output stream word valid
//   m_ready       downstream accept
//   m_data        output stream word
//   rd_count      accepted-word counter, wraps at 16 bits (FIFO_RD_CNT_EN only)

module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count
`endif
);

    logic       run_q;
    logic       inflight;
    logic       pop;
    logic [1:0] count;
    logic [2:0] occupancy;
    logic [2:0] limit;

    assign pop = m_valid && m_ready;

    // Issue while buffered + in-flight words, less the one leaving this cycle,
    // stay below the buffer depth. Written as an addition on both sides to
    // avoid an unsigned subtraction.
    assign occupancy  = {1'b0, count} + {2'b00, inflight};
    assign limit      = 3'(SKID_DEPTH) + {2'b00, pop};
    // run_q holds issue off until the first clock edge after reset release.
    assign fifo_rd_en = run_q && !fifo_empty && (occupancy < limit);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            run_q    <= 1'b0;
            inflight <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            inflight <= fifo_rd_en;
        end
    end

    // The FIFO presents the popped word one cycle later, so the in-flight
    // flag doubles as the buffer write strobe.
    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rstb    (rstb),
        .wr_en   (inflight),
        .wr_data (fifo_rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - directed self-checking bench for fifo_rd_ctrl

module tb_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = 32'h0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] rd_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] fq[$];
    logic        ovr_en = 1'b0;
    logic        ovr_val = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(
        .DATA_WIDTH (32),
        .SKID_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rstb         (rstb),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count     (rd_count)
`endif
    );

    // FIFO read-side model: registered data one cycle after a pop.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
            else               fifo_rd_data <= 32'hDEAD_DEAD;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle: drive inputs at the falling edge, sample 1 ns later.
    task automatic step(input logic rdy);
        @(negedge clk);
        m_ready    = rdy;
        fifo_empty = ovr_en ? ovr_val : (fq.size() == 0);
        #1;
    endtask

    task automatic do_reset();
        rstb   = 1'b0;
        ovr_en = 1'b0;
        fq.delete();
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_reset();
        rstb    = 1'b0;
        ovr_en  = 1'b1;
        ovr_val = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step(1'b1);
            n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
            n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
            n_cmp++; if (m_data !== 32'h0) begin n_bad++; $display("FAIL reset_m_data: got %h want 00000000", m_data); end
        end
        ovr_en = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_single();
        int rd_n = 0, rd_first = -1, v_n = 0, v_first = -1;
        logic [31:0] v_data = 32'h0;
        fq.push_back(32'hA5A5_A5A5);
        for (int c = 0; c < 8; c++) begin
            step(1'b1);
            if (fifo_rd_en) begin rd_n++; if (rd_first < 0) rd_first = c; end
            if (m_valid) begin v_n++; if (v_first < 0) begin v_first = c; v_data = m_data; end end
        end
        n_cmp++; if (rd_n != 1) begin n_bad++; $display("FAIL single_pops: got %0d want 1", rd_n); end
        n_cmp++; if (rd_first != 0) begin n_bad++; $display("FAIL single_rd_cycle: got %0d want 0", rd_first); end
        n_cmp++; if (v_n != 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d want 1", v_n); end
        n_cmp++; if (v_first != 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", v_first); end
        n_cmp++; if (v_data !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL single_data: got %h want a5a5a5a5", v_data); end
    endtask

    task automatic test_stream();
        logic [31:0] got[$];
        logic [31:0] act;
        int v_first = -1, v_last = -1;
        for (int i = 1; i <= 8; i++) fq.push_back(32'(i));
        for (int c = 0; c < 14; c++) begin
            step(1'b1);
            if (m_valid) begin
                got.push_back(m_data);
                if (v_first < 0) v_first = c;
                v_last = c;
            end
        end
        n_cmp++; if (got.size() != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", got.size()); end
        n_cmp++; if (v_first != 2 || v_last != 9) begin n_bad++; $display("FAIL stream_window: got %0d..%0d want 2..9", v_first, v_last); end
        for (int i = 0; i < 8; i++) begin
            act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
            n_cmp++; if (act !== 32'(i + 1)) begin n_bad++; $display("FAIL stream_word%0d: got %h want %h", i, act, 32'(i + 1)); end
        end
    endtask

    task automatic test_backpressure();
        int rd_n = 0, stall_bad = 0;
        logic [31:0] got[$];
        logic [31:0] act;
        for (int i = 1; i <= 4; i++) fq.push_back(32'(i));
        for (int c = 0; c < 10; c++) begin
            step(1'b0);
            if (fifo_rd_en) rd_n++;
            if (c >= 2 && (m_valid !== 1'b1 || m_data !== 32'h1)) stall_bad++;
        end
        n_cmp++; if (rd_n != 2) begin n_bad++; $display("FAIL bp_pops: got %0d want 2", rd_n); end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
        for (int c = 0; c < 10; c++) begin
            step(1'b1);
            if (m_valid) got.push_back(m_data);
        end
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL bp_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
            n_cmp++; if (act !== 32'(i + 1)) begin n_bad++; $display("FAIL bp_word%0d: got %h want %h", i, act, 32'(i + 1)); end
        end
    endtask

    task automatic test_empty_race();
        int rd_n = 0;
        logic [31:0] got[$];
        logic [31:0] rest[$];
        logic [31:0] act;
        fq.push_back(32'hB1); fq.push_back(32'hB2); fq.push_back(32'hB3);
        step(1'b1);
        n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL race_first_pop: got %b want 1", fifo_rd_en); end
        ovr_en = 1'b1; ovr_val = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            if (fifo_rd_en) rd_n++;
            if (m_valid) got.push_back(m_data);
        end
        n_cmp++; if (rd_n != 0) begin n_bad++; $display("FAIL race_no_pop: got %0d want 0", rd_n); end
        act = (got.size() == 1) ? got[0] : 32'hxxxx_xxxx;
        n_cmp++; if (act !== 32'hB1) begin n_bad++; $display("FAIL race_inflight_word: got %h (n=%0d) want 000000b1", act, got.size()); end
        ovr_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1);
            if (m_valid) rest.push_back(m_data);
        end
        act = (rest.size() == 2) ? rest[0] : 32'hxxxx_xxxx;
        n_cmp++; if (act !== 32'hB2) begin n_bad++; $display("FAIL race_resume0: got %h (n=%0d) want 000000b2", act, rest.size()); end
        act = (rest.size() == 2) ? rest[1] : 32'hxxxx_xxxx;
        n_cmp++; if (act !== 32'hB3) begin n_bad++; $display("FAIL race_resume1: got %h (n=%0d) want 000000b3", act, rest.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got[$];
        logic [31:0] act;
        for (int i = 1; i <= 6; i++) fq.push_back(32'hC0 + 32'(i));
        for (int c = 0; c < 4; c++) step(1'b0);
        rstb = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 32'h0) begin n_bad++; $display("FAIL midrst_m_data: got %h want 00000000", m_data); end
        step(1'b1);
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL midrst_rd_en: got %b want 0", fifo_rd_en); end
        @(negedge clk);
        rstb = 1'b1;
        #1;
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_release_rd_en: got %b want 0", fifo_rd_en); end
        for (int c = 0; c < 12; c++) begin
            step(1'b1);
            if (m_valid) got.push_back(m_data);
        end
        n_cmp++; if (got.size() != 4) begin n_bad++; $display("FAIL midrst_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            act = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
            n_cmp++; if (act !== 32'hC3 + 32'(i)) begin n_bad++; $display("FAIL midrst_word%0d: got %h want %h", i, act, 32'hC3 + 32'(i)); end
        end
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_counter();
        int cyc = 0;
        do_reset();
        n_cmp++; if (rd_count !== 16'h0) begin n_bad++; $display("FAIL cnt_reset: got %h want 0000", rd_count); end
        for (int i = 0; i < 65535; i++) fq.push_back(32'(i));
        step(1'b1);
        while ((fq.size() != 0 || m_valid || cyc < 4) && cyc < 70000) begin
            step(1'b1);
            cyc++;
        end
        n_cmp++; if (cyc >= 70000) begin n_bad++; $display("FAIL cnt_drain_timeout: got %0d cycles want < 70000", cyc); end
        n_cmp++; if (rd_count !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_preset: got %h want ffff", rd_count); end
        fq.push_back(32'h1); fq.push_back(32'h2);
        for (int c = 0; c < 6; c++) step(1'b1);
        n_cmp++; if (rd_count !== 16'h0001) begin n_bad++; $display("FAIL cnt_wrap: got %h want 0001", rd_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_empty_race();
        test_reset_mid();
`ifdef FIFO_RD_CNT_EN
        test_counter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of FIFO read data and output stream data.
REQ-002 Parameter SKID_DEPTH, default 2, fixed: output buffer entries; other values unsupported.
REQ-003 clk  input  1  single clock shared with the FIFO read side.
REQ-004 rstb  input  1  reset, asynchronous assert, active-low.
REQ-005 fifo_empty  input  1  FIFO read-side empty flag.
REQ-006 fifo_rd_en  output  1  FIFO pop request.
REQ-007 fifo_rd_data  input  DATA_WIDTH  FIFO registered read data, valid one cycle after a pop.
REQ-008 m_valid  output  1  output stream word valid.
REQ-009 m_ready  input  1  downstream accept.
REQ-010 m_data  output  DATA_WIDTH  output stream word.
REQ-011 rd_count  output  16  accepted-word counter; present only with FIFO_RD_CNT_EN.

Function
REQ-012 Transfer on the output occurs in a cycle with m_valid && m_ready (pop).
REQ-013 fifo_rd_en SHALL be high only if fifo_empty is low, so every fifo_rd_en pulse is a real FIFO pop.
REQ-014 fifo_rd_en SHALL be high when !fifo_empty && (count + inflight - pop) < 2; count = buffered words (0..2), inflight = 1 if fifo_rd_en was high last cycle.
REQ-015 In the cycle after fifo_rd_en, fifo_rd_data SHALL be written into the skid buffer tail.
REQ-016 Buffer FSM states: EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-017 Transitions: write only -> count+1; pop only -> count-1; write and pop in the same cycle -> count unchanged, order preserved.
REQ-018 m_valid SHALL be high when count != 0; m_data SHALL be the oldest buffered word.
REQ-019 While m_valid && !m_ready, m_data SHALL stay stable and m_valid SHALL stay high.
REQ-020 Latency: fifo_rd_en in cycle N -> m_valid in cycle N+2 when the buffer was EMPTY.
REQ-021 Throughput: with fifo_empty low and m_ready high, one word per cycle sustained, no bubbles after the first word.
REQ-022 Words SHALL never be dropped, duplicated or reordered.
REQ-023 In FULL with m_ready low, fifo_rd_en SHALL stay low.
REQ-024 fifo_empty rising with a pop in flight: the in-flight word is still captured and delivered.

Reset
REQ-025 While rstb is low: m_valid = 0, m_data = 0, fifo_rd_en = 0, count = 0, inflight = 0, FSM = EMPTY.
REQ-026 Reset mid-operation SHALL discard buffered and in-flight words.
REQ-027 The first fifo_rd_en is no earlier than the first clk edge after rstb deasserts.

Configuration
REQ-028 Macro FIFO_RD_CNT_EN defined: rd_count is present, resets to 0, increments by 1 per pop, and wraps 0xFFFF -> 0x0000.
REQ-029 Macro FIFO_RD_CNT_EN undefined: the rd_count port and counter logic are absent; all other behaviour is identical.

Structure
REQ-030 Shared package fifo_pkg SHALL hold the default DATA_WIDTH, SKID_DEPTH, the FSM state encoding (EMPTY/ONE/FULL), and the counter width (16).
REQ-031 The 2-entry buffer with FSM SHALL be sub-module fifo_rd_skid; fifo_rd_ctrl holds the issue/inflight logic and the optional counter.

Verification
REQ-032 Reset: rstb low with fifo_empty = 0 -> fifo_rd_en = 0, m_valid = 0, m_data = 0x00000000.
REQ-033 Single word: FIFO holds 0xA5A5A5A5, m_ready = 1 -> fifo_rd_en one cycle (N); m_valid and m_data = 0xA5A5A5A5 in N+2 for one cycle.
REQ-034 Streaming: FIFO holds 0x1..0x8, m_ready = 1 -> m_data 0x1..0x8 on 8 consecutive cycles, no gaps.
REQ-035 Backpressure: FIFO holds 0x1..0x4, m_ready = 0 for 10 cycles -> exactly 2 pops, m_data = 0x1 stable; then m_ready = 1 -> 0x1, 0x2, 0x3, 0x4 in order.
REQ-036 Empty race: fifo_empty rises the cycle after a pop -> word delivered, no further fifo_rd_en; rstb pulse mid-stream -> m_valid = 0 and resume without stale data.
REQ-037 FIFO_RD_CNT_EN: rd_count preset by 65535 pops, then 2 more pops -> rd_count = 0x0001.
